// File: rtl/rgb_to_gray.sv
// ---------------------------------------------------------------------------
// rgb_to_gray
//   Streaming RGB-to-grayscale converter feeding a byte-wide capture buffer.
//   Each valid RGB pixel becomes an 8-bit luma value one clock later. Every
//   valid luma value is then written to consecutive buffer addresses so a
//   downstream stage or a host can fetch it by address.
//
//   Luma: (R>>2)+(R>>5)+(G>>1)+(G>>4)+(B>>4)+(B>>5), weights 0.28125/0.5625/
//   0.09375. The largest possible sum is 234, so it always fits in 8 bits.
//
//   Optional build macro: RGB_TO_GRAY_WRAP_EN
//     undefined : saturating buffer; writes are dropped once full, and
//                 overflow sets when a valid pixel arrives while full.
//     defined   : ring buffer; the pointer wraps DEPTH-1 -> 0, full is tied
//                 low, and overflow sets on the first wrap.
//
// Parameters
//   DEPTH : capture buffer entries (bytes)
//   AW    : address / count width, 2**AW >= DEPTH
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   red_i        in   [7:0]    red component
//   green_i      in   [7:0]    green component
//   blue_i       in   [7:0]    blue component
//   cam_done_i   in            pixel-valid strobe
//   grayscale_o  out  [7:0]    registered luma (0 when not valid)
//   done_o       out           registered valid for grayscale_o
//   rd_addr_i    in   [AW-1:0] buffer read address
//   rd_data_o    out  [7:0]    buffer read data, 1-clock latency
//   wr_count_o   out  [AW-1:0] pixels stored / current write pointer
//   full_o       out           buffer full (combinational)
//   overflow_o   out           sticky overflow / wrap flag
// ---------------------------------------------------------------------------
module rgb_to_gray #(
   parameter int unsigned DEPTH = 51200,
   parameter int unsigned AW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    red_i,
   input  logic [7:0]    green_i,
   input  logic [7:0]    blue_i,
   input  logic          cam_done_i,
   output logic [7:0]    grayscale_o,
   output logic          done_o,
   input  logic [AW-1:0] rd_addr_i,
   output logic [7:0]    rd_data_o,
   output logic [AW-1:0] wr_count_o,
   output logic          full_o,
   output logic          overflow_o
);

   // Memory index width; AW may be wider than the buffer actually needs.
   localparam int unsigned MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // DEPTH held one bit wider than AW so DEPTH == 2**AW still compares
   // correctly.
   localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

   logic [7:0] gray_c;
   logic       we_c;
   logic       rd_in_range_c;
   logic [7:0] mem [DEPTH];

   // Luma approximation. An 8-bit sum is exact because the maximum is 234.
   always_comb begin
      gray_c = (red_i   >> 2) + (red_i   >> 5)
             + (green_i >> 1) + (green_i >> 4)
             + (blue_i  >> 4) + (blue_i  >> 5);
   end

   // Conversion stage: one clock of latency, and the output is zeroed when
   // no pixel is valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grayscale_o <= 8'd0;
         done_o      <= 1'b0;
      end else if (cam_done_i) begin
         grayscale_o <= gray_c;
         done_o      <= 1'b1;
      end else begin
         grayscale_o <= 8'd0;
         done_o      <= 1'b0;
      end
   end

`ifdef RGB_TO_GRAY_WRAP_EN
   // Ring buffer: always write; the pointer wraps and the first wrap is
   // recorded.
   assign full_o = 1'b0;
   assign we_c   = done_o;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_count_o <= '0;
         overflow_o <= 1'b0;
      end else if (we_c) begin
         if ({1'b0, wr_count_o} == DEPTH_X - (AW+1)'(1)) begin
            wr_count_o <= '0;
            overflow_o <= 1'b1;
         end else begin
            wr_count_o <= wr_count_o + AW'(1);
         end
      end
   end
`else
   // Saturating buffer: once full, drop further pixels and flag overflow.
   assign full_o = ({1'b0, wr_count_o} == DEPTH_X);
   assign we_c   = done_o & ~full_o;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_count_o <= '0;
         overflow_o <= 1'b0;
      end else if (done_o) begin
         if (full_o) begin
            overflow_o <= 1'b1;
         end else begin
            wr_count_o <= wr_count_o + AW'(1);
         end
      end
   end
`endif

   // Capture buffer write port. The contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we_c) begin
         mem[MW'(wr_count_o)] <= grayscale_o;
      end
   end

   assign rd_in_range_c = ({1'b0, rd_addr_i} < DEPTH_X);

   // Synchronous read. On a same-address collision it returns the old data
   // because the write above lands after this read samples. Addresses
   // outside the buffer read back as zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_o <= 8'd0;
      end else if (rd_in_range_c) begin
         rd_data_o <= mem[MW'(rd_addr_i)];
      end else begin
         rd_data_o <= 8'd0;
      end
   end

endmodule

// File: tb/tb_rgb_to_gray.sv
// ---------------------------------------------------------------------------
// tb_rgb_to_gray
//   Self-checking bench for rgb_to_gray. It drives one full-size instance and
//   one DEPTH=8 instance, and checks both against a reference model that
//   computes luma with integer division and buffer contents with plain
//   arrays.
// ---------------------------------------------------------------------------
module tb_rgb_to_gray;

   localparam int unsigned AW     = 16;
   localparam int unsigned DEPTH  = 51200;
   localparam int unsigned SDEPTH = 8;
   localparam int unsigned NPIX   = 16384;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    red, green, blue;
   logic          cam_done;
   logic [AW-1:0] rd_addr, rd_addr_s;

   logic [7:0]    gray, gray_s;
   logic          done, done_s;
   logic [7:0]    rd_data, rd_data_s;
   logic [AW-1:0] wr_count, wr_count_s;
   logic          full, full_s;
   logic          overflow, overflow_s;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] exp_mem [NPIX];
   logic [7:0] sg      [10];
   logic [7:0] smem    [SDEPTH];
   logic [7:0] old0;
   logic [7:0] p;
   int         nstored;
   int         r0, g0, b0;

   always #5 clk = ~clk;

   rgb_to_gray #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst), .red_i(red), .green_i(green), .blue_i(blue),
      .cam_done_i(cam_done), .grayscale_o(gray), .done_o(done),
      .rd_addr_i(rd_addr), .rd_data_o(rd_data), .wr_count_o(wr_count),
      .full_o(full), .overflow_o(overflow));

   rgb_to_gray #(.DEPTH(SDEPTH), .AW(AW)) dut_s (
      .clk(clk), .rst(rst), .red_i(red), .green_i(green), .blue_i(blue),
      .cam_done_i(cam_done), .grayscale_o(gray_s), .done_o(done_s),
      .rd_addr_i(rd_addr_s), .rd_data_o(rd_data_s), .wr_count_o(wr_count_s),
      .full_o(full_s), .overflow_o(overflow_s));

   // Reference luma: the weighted sum with truncating integer division.
   function automatic logic [7:0] ref_gray(input int r, input int g, input int b);
      return 8'(r/4 + r/32 + g/2 + g/16 + b/16 + b/32);
   endfunction

`ifdef RGB_TO_GRAY_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   // Small-buffer expectations after n valid pixels have been presented to
   // the store stage.
   function automatic int s_count(input int n);
      if (WRAP) return n % SDEPTH;
      return (n < SDEPTH) ? n : SDEPTH;
   endfunction
   function automatic int s_full(input int n);
      if (WRAP) return 0;
      return (n >= SDEPTH) ? 1 : 0;
   endfunction
   function automatic int s_ovf(input int n);
      if (WRAP) return (n >= SDEPTH) ? 1 : 0;
      return (n > SDEPTH) ? 1 : 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int r, input int g, input int b, input logic v);
      red      = 8'(r);
      green    = 8'(g);
      blue     = 8'(b);
      cam_done = v;
   endtask

   initial begin
      int cr[5] = '{255, 0, 0, 255, 0};
      int cgv[5] = '{255, 0, 255, 0, 0};
      int cb[5] = '{255, 0, 0, 0, 255};
      int ce[5] = '{234, 0, 142, 70, 22};
      logic gapv[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

      rst = 1'b1;
      drive(0, 0, 0, 1'b0);
      rd_addr   = '0;
      rd_addr_s = '0;
      step();
      step();

      // Values held in reset
      check("rst_gray",     32'(gray),       0);
      check("rst_done",     32'(done),       0);
      check("rst_count",    32'(wr_count),   0);
      check("rst_full",     32'(full),       0);
      check("rst_overflow", 32'(overflow),   0);
      check("rst_rd_data",  32'(rd_data),    0);
      check("rst_count_s",  32'(wr_count_s), 0);
      rst = 1'b0;

      // First pixel: R=4 G=2 B=16 gives 3
      drive(4, 2, 16, 1'b1);
      step();
      check("t1_gray",  32'(gray), 3);
      check("t1_done",  32'(done), 1);
      check("t1_count", 32'(wr_count), 0);
      drive(0, 0, 0, 1'b0);
      step();
      check("t1_gray_idle", 32'(gray), 0);
      check("t1_done_idle", 32'(done), 0);
      check("t1_count1",    32'(wr_count), 1);
      rd_addr = '0;
      step();
      check("t1_mem0", 32'(rd_data), 3);
      exp_mem[0] = 8'd3;
      nstored = 1;

      // Corner colours, back to back
      for (int i = 0; i < 5; i++) begin
         drive(cr[i], cgv[i], cb[i], 1'b1);
         step();
         check("corner_gray", 32'(gray), 32'(ce[i]));
         check("corner_ref",  32'(gray), 32'(ref_gray(cr[i], cgv[i], cb[i])));
         check("corner_done", 32'(done), 1);
         exp_mem[nstored] = 8'(ce[i]);
         nstored++;
      end
      drive(0, 0, 0, 1'b0);
      step();
      check("corner_done_idle", 32'(done), 0);
      check("corner_count", 32'(wr_count), 32'(nstored));
      for (int a = 0; a < nstored; a++) begin
         rd_addr = AW'(a);
         step();
         check("corner_mem", 32'(rd_data), 32'(exp_mem[a]));
      end

      // Valid, idle, idle, valid: only valid pixels advance the pointer
      for (int i = 0; i < 4; i++) begin
         if (gapv[i]) begin
            r0 = int'($urandom_range(255));
            g0 = int'($urandom_range(255));
            b0 = int'($urandom_range(255));
            drive(r0, g0, b0, 1'b1);
            exp_mem[nstored] = ref_gray(r0, g0, b0);
            nstored++;
         end else begin
            drive(0, 0, 0, 1'b0);
         end
         step();
         check("gap_done", 32'(done), 32'(gapv[i]));
         if (gapv[i]) check("gap_gray", 32'(gray), 32'(exp_mem[nstored-1]));
         else         check("gap_gray_zero", 32'(gray), 0);
      end
      drive(0, 0, 0, 1'b0);
      step();
      step();
      check("gap_count", 32'(wr_count), 32'(nstored));
      for (int a = nstored - 2; a < nstored; a++) begin
         rd_addr = AW'(a);
         step();
         check("gap_mem", 32'(rd_data), 32'(exp_mem[a]));
      end

      // Asynchronous reset between edges, mid-stream
      drive(10, 200, 30, 1'b1);
      step();
      drive(250, 100, 50, 1'b1);
      step();
      #2;
      rst = 1'b1;
      #1;
      check("arst_gray",     32'(gray),       0);
      check("arst_done",     32'(done),       0);
      check("arst_count",    32'(wr_count),   0);
      check("arst_rd_data",  32'(rd_data),    0);
      check("arst_count_s",  32'(wr_count_s), 0);
      drive(0, 0, 0, 1'b0);
      step();
      rst = 1'b0;
      r0 = 90; g0 = 180; b0 = 45;
      drive(r0, g0, b0, 1'b1);
      step();
      drive(0, 0, 0, 1'b0);
      step();
      check("arst_first_count", 32'(wr_count), 1);
      rd_addr = '0;
      step();
      old0 = ref_gray(r0, g0, b0);
      check("arst_first_addr0", 32'(rd_data), 32'(old0));

      // Full 128x128 frame, back to back, reading address 0 throughout
      rst = 1'b1;
      step();
      rst = 1'b0;
      rd_addr = '0;
      for (int k = 0; k < NPIX; k++) begin
         do begin
            b0 = int'($urandom_range(255));
            g0 = int'($urandom_range(255));
            r0 = int'($urandom_range(255));
            p  = ref_gray(r0, g0, b0);
         end while (k == 0 && p == old0);
         drive(r0, g0, b0, 1'b1);
         exp_mem[k] = p;
         step();
         if (k == 1) check("rbw_old_data", 32'(rd_data), 32'(old0));
         if (k == 2) check("rbw_new_data", 32'(rd_data), 32'(exp_mem[0]));
      end
      drive(0, 0, 0, 1'b0);
      step();
      step();
      check("frame_count",    32'(wr_count), NPIX);
      check("frame_full",     32'(full),     0);
      check("frame_overflow", 32'(overflow), 0);
      for (int a = 0; a < int'(NPIX); a++) begin
         rd_addr = AW'(a);
         step();
         check("frame_mem", 32'(rd_data), 32'(exp_mem[a]));
      end
      rd_addr = AW'(DEPTH);
      step();
      check("rd_oob_depth", 32'(rd_data), 0);
      rd_addr = '1;
      step();
      check("rd_oob_max", 32'(rd_data), 0);

      // Small buffer: 10 valid pixels into 8 entries
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int j = 0; j < 10; j++) begin
         r0 = int'($urandom_range(255));
         g0 = int'($urandom_range(255));
         b0 = int'($urandom_range(255));
         sg[j] = ref_gray(r0, g0, b0);
         drive(r0, g0, b0, 1'b1);
         step();
         check("small_count", 32'(wr_count_s), 32'(s_count(j)));
         check("small_full",  32'(full_s),     32'(s_full(j)));
         check("small_ovf",   32'(overflow_s), 32'(s_ovf(j)));
      end
      drive(0, 0, 0, 1'b0);
      step();
      check("small_count_end", 32'(wr_count_s), 32'(s_count(10)));
      check("small_full_end",  32'(full_s),     32'(s_full(10)));
      check("small_ovf_end",   32'(overflow_s), 32'(s_ovf(10)));
      for (int k = 0; k < 10; k++) begin
         if (WRAP || k < int'(SDEPTH)) smem[k % SDEPTH] = sg[k];
      end
      for (int a = 0; a < int'(SDEPTH); a++) begin
         rd_addr_s = AW'(a);
         step();
         check("small_mem", 32'(rd_data_s), 32'(smem[a]));
      end
      rd_addr_s = AW'(SDEPTH);
      step();
      check("small_rd_oob", 32'(rd_data_s), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
